// File: rtl/speculation_predictor_if.sv
// Speculation bus between fetch / program counter and the branch predictor.
// master: the predictor (drives the begin-speculation side).
// slave : fetch and program counter (drive fetch info and resolution).
interface speculation_predictor_if #(
    parameter int DATABITWIDTH = 16
);
    logic                    clk_en;
    logic                    StallEnable;
    logic                    FetchBranch;
    logic                    FetchRelative;
    logic [DATABITWIDTH-1:0] FetchProgramCounter;
    logic [DATABITWIDTH-1:0] BranchImmediate;
    logic                    BeginSpeculationPulse;
    logic                    PredictingTrue;
    logic                    RelativeSpeculation;
    logic [DATABITWIDTH-1:0] SpeculativeDestination;
    logic                    Speculating;
    logic                    FetchHold;
    logic                    EndSpeculationPulse;
    logic                    MispredictedSpeculationPulse;
    logic [DATABITWIDTH-1:0] ActualDestination;

    modport master (
        input  clk_en, StallEnable, FetchBranch, FetchRelative,
               FetchProgramCounter, BranchImmediate,
               EndSpeculationPulse, MispredictedSpeculationPulse, ActualDestination,
        output BeginSpeculationPulse, PredictingTrue, RelativeSpeculation,
               SpeculativeDestination, Speculating, FetchHold
    );

    modport slave (
        output clk_en, StallEnable, FetchBranch, FetchRelative,
               FetchProgramCounter, BranchImmediate,
               EndSpeculationPulse, MispredictedSpeculationPulse, ActualDestination,
        input  BeginSpeculationPulse, PredictingTrue, RelativeSpeculation,
               SpeculativeDestination, Speculating, FetchHold
    );
endinterface

// File: rtl/speculation_predictor.sv
// Direct-mapped branch predictor / target buffer with 2-bit counters.
// Starts one speculation at a time and trains the table at resolution.
// Optional feature macro: SPECULATION_PREDICTOR_STATS_EN adds saturating
// PredictionCount / MispredictCount outputs.
module speculation_predictor #(
    parameter int DATABITWIDTH = 16,
    parameter int ENTRIES      = 8
) (
    input  logic                          clk,
    input  logic                          async_rst_n,
    speculation_predictor_if.master       bus
`ifdef SPECULATION_PREDICTOR_STATS_EN
    ,
    output logic [15:0]                   PredictionCount,
    output logic [15:0]                   MispredictCount
`endif
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = DATABITWIDTH - IDXW;

    typedef enum logic {IDLE = 1'b0, SPEC = 1'b1} state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    // Table contents flattened so each entry can own its register process.
    logic [ENTRIES-1:0]              w_valid;
    logic [ENTRIES*TAGW-1:0]         w_tag_flat;
    logic [ENTRIES*DATABITWIDTH-1:0] w_target_flat;
    logic [ENTRIES*2-1:0]            w_cnt_flat;

    logic [IDXW-1:0]             w_idx;
    logic [TAGW-1:0]             w_tag;
    logic [DATABITWIDTH-1:0]     w_entry_target;
    logic [1:0]                  w_entry_cnt;
    logic [DATABITWIDTH-1:0]     w_fall;
    logic                        w_active;
    logic                        w_hit;
    logic                        w_taken;
    logic                        w_issue;
    logic                        w_end;
    logic                        w_res_taken;

    logic [IDXW-1:0]             r_cap_idx;
    logic [TAGW-1:0]             r_cap_tag;
    logic                        r_cap_pred;
    logic                        r_cap_hit;
    logic [DATABITWIDTH-1:0]     r_cap_fall;

    assign w_active       = bus.clk_en && !bus.StallEnable;
    assign w_idx          = bus.FetchProgramCounter[IDXW-1:0];
    assign w_tag          = bus.FetchProgramCounter[DATABITWIDTH-1:IDXW];
    assign w_entry_target = w_target_flat[w_idx*DATABITWIDTH +: DATABITWIDTH];
    assign w_entry_cnt    = w_cnt_flat[w_idx*2 +: 2];
    assign w_hit          = w_valid[w_idx] && (w_tag_flat[w_idx*TAGW +: TAGW] == w_tag);
    assign w_taken        = w_hit && w_entry_cnt[1];
    assign w_fall         = bus.FetchProgramCounter + DATABITWIDTH'(1);
    // Reset gates the issue path so the combinational pulse is 0 during reset.
    assign w_issue        = async_rst_n && (r_state == IDLE) && bus.FetchBranch && w_active;
    assign w_end          = (r_state == SPEC) && bus.EndSpeculationPulse && w_active;
    // A mispredicted taken guess only counts as not-taken if the PC fell through.
    assign w_res_taken    = !bus.MispredictedSpeculationPulse ? r_cap_pred :
                            (!r_cap_pred || (bus.ActualDestination != r_cap_fall));
    assign bus.Speculating = (r_state == SPEC);

    // Next-state and zero-latency speculation outputs.
    always_comb begin
        w_state_next               = r_state;
        bus.BeginSpeculationPulse  = 1'b0;
        bus.PredictingTrue         = 1'b0;
        bus.RelativeSpeculation    = 1'b0;
        bus.SpeculativeDestination = '0;
        bus.FetchHold              = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    bus.BeginSpeculationPulse  = 1'b1;
                    bus.PredictingTrue         = w_taken;
                    bus.RelativeSpeculation    = bus.FetchRelative;
                    bus.SpeculativeDestination = bus.FetchRelative ? bus.BranchImmediate
                                                                   : w_entry_target;
                    w_state_next               = SPEC;
                end
            end
            SPEC: begin
                bus.FetchHold = bus.FetchBranch;
                if (w_end) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the lookup context of the issuing branch for later training.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_cap_idx  <= '0;
            r_cap_tag  <= '0;
            r_cap_pred <= 1'b0;
            r_cap_hit  <= 1'b0;
            r_cap_fall <= '0;
        end else if (w_issue) begin
            r_cap_idx  <= w_idx;
            r_cap_tag  <= w_tag;
            r_cap_pred <= w_taken;
            r_cap_hit  <= w_hit;
            r_cap_fall <= w_fall;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                    r_valid;
            logic [TAGW-1:0]         r_tag;
            logic [DATABITWIDTH-1:0] r_target;
            logic [1:0]              r_cnt;
            logic                    w_we;

            assign w_we = w_end && (r_cap_idx == IDXW'(gi));
            assign w_valid[gi]                                   = r_valid;
            assign w_tag_flat[gi*TAGW +: TAGW]                   = r_tag;
            assign w_target_flat[gi*DATABITWIDTH +: DATABITWIDTH] = r_target;
            assign w_cnt_flat[gi*2 +: 2]                         = r_cnt;

            // Train this entry with the resolved outcome of the captured branch.
            always_ff @(posedge clk or negedge async_rst_n) begin
                if (!async_rst_n) begin
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= '0;
                    r_cnt    <= 2'b01;
                end else if (w_we) begin
                    if (w_res_taken) begin
                        r_target <= bus.ActualDestination;
                        if (r_cap_hit) begin
                            if (r_cnt != 2'b11) r_cnt <= r_cnt + 2'b01;
                        end else begin
                            r_valid <= 1'b1;
                            r_tag   <= r_cap_tag;
                            r_cnt   <= 2'b10;
                        end
                    end else if (r_cap_hit) begin
                        if (r_cnt != 2'b00) r_cnt <= r_cnt - 2'b01;
                    end
                end
            end
        end
    endgenerate

`ifdef SPECULATION_PREDICTOR_STATS_EN
    logic [15:0] r_pred_cnt;
    logic [15:0] r_mis_cnt;

    // Saturating issue and mispredict statistics.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_pred_cnt <= '0;
            r_mis_cnt  <= '0;
        end else begin
            if (w_issue && (r_pred_cnt != 16'hFFFF)) r_pred_cnt <= r_pred_cnt + 16'd1;
            if (w_end && bus.MispredictedSpeculationPulse && (r_mis_cnt != 16'hFFFF))
                r_mis_cnt <= r_mis_cnt + 16'd1;
        end
    end

    assign PredictionCount = r_pred_cnt;
    assign MispredictCount = r_mis_cnt;
`endif
endmodule

// File: tb/tb_speculation_predictor.sv
// Self-checking bench for speculation_predictor: directed scenarios plus
// randomized traffic compared against a table-level behavioural model.
module tb_speculation_predictor;
    logic clk = 1'b0;
    logic async_rst_n;
    always #5 clk = ~clk;

    speculation_predictor_if #(.DATABITWIDTH(16)) bus ();

`ifdef SPECULATION_PREDICTOR_STATS_EN
    logic [15:0] pred_count;
    logic [15:0] mis_count;
`endif

    speculation_predictor #(.DATABITWIDTH(16), .ENTRIES(8)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .bus         (bus)
`ifdef SPECULATION_PREDICTOR_STATS_EN
        ,
        .PredictionCount (pred_count),
        .MispredictCount (mis_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    bit m_valid [8];
    int m_tag   [8];
    int m_tgt   [8];
    int m_cnt   [8];
    bit m_busy;
    int c_idx, c_tag, c_fall;
    bit c_pred, c_hit;
    int m_pcount, m_mcount;

    // copies of the driven inputs
    bit d_fb, d_rel, d_en, d_misp, d_ce, d_stall;
    int d_pc, d_imm, d_act;

    typedef struct {
        bit fb; bit rel; int pc; int imm; bit en; bit misp; int act; bit ce; bit stall;
        int want_pred; int want_dest;
    } stim_t;

    function automatic stim_t S(bit fb, bit rel, int pc, int imm, bit en, bit misp,
                                int act, bit ce, bit stall, int wp, int wd);
        stim_t s;
        s.fb = fb; s.rel = rel; s.pc = pc; s.imm = imm; s.en = en; s.misp = misp;
        s.act = act; s.ce = ce; s.stall = stall; s.want_pred = wp; s.want_dest = wd;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
        m_busy = 0; m_pcount = 0; m_mcount = 0;
        c_idx = 0; c_tag = 0; c_fall = 0; c_pred = 0; c_hit = 0;
    endtask

    function automatic bit model_hit(int pc);
        return m_valid[pc % 8] && (m_tag[pc % 8] == pc / 8);
    endfunction

    function automatic logic [20:0] expect_out();
        bit issue;
        bit taken;
        int dest;
        issue = async_rst_n && !m_busy && d_fb && d_ce && !d_stall;
        taken = model_hit(d_pc) && (m_cnt[d_pc % 8] >= 2);
        dest  = !issue ? 0 : (d_rel ? d_imm : m_tgt[d_pc % 8]);
        return {issue, issue && taken, issue && d_rel, 16'(dest),
                async_rst_n && m_busy && d_fb, async_rst_n && m_busy};
    endfunction

    function automatic logic [20:0] observe();
        return {bus.BeginSpeculationPulse, bus.PredictingTrue, bus.RelativeSpeculation,
                bus.SpeculativeDestination, bus.FetchHold, bus.Speculating};
    endfunction

    // Advance the model across one active clock edge.
    task automatic model_commit();
        bit taken;
        int i;
        if (!(d_ce && !d_stall)) return;
        if (!m_busy && d_fb) begin
            c_idx  = d_pc % 8;
            c_tag  = d_pc / 8;
            c_hit  = model_hit(d_pc);
            c_pred = c_hit && (m_cnt[c_idx] >= 2);
            c_fall = (d_pc + 1) % 65536;
            m_busy = 1;
            if (m_pcount < 65535) m_pcount++;
        end else if (m_busy && d_en) begin
            if (!d_misp)      taken = c_pred;
            else if (!c_pred) taken = 1;
            else              taken = (d_act != c_fall);
            i = c_idx;
            if (taken && c_hit) begin
                m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                m_tgt[i] = d_act;
            end else if (taken) begin
                m_valid[i] = 1; m_tag[i] = c_tag; m_tgt[i] = d_act; m_cnt[i] = 2;
            end else if (c_hit) begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
            m_busy = 0;
            if (d_misp && m_mcount < 65535) m_mcount++;
        end
    endtask

    task automatic drive(stim_t s);
        d_fb = s.fb; d_rel = s.rel; d_pc = s.pc; d_imm = s.imm; d_en = s.en;
        d_misp = s.misp; d_act = s.act; d_ce = s.ce; d_stall = s.stall;
        bus.FetchBranch                  = s.fb;
        bus.FetchRelative                = s.rel;
        bus.FetchProgramCounter          = 16'(s.pc);
        bus.BranchImmediate              = 16'(s.imm);
        bus.EndSpeculationPulse          = s.en;
        bus.MispredictedSpeculationPulse = s.misp;
        bus.ActualDestination            = 16'(s.act);
        bus.clk_en                       = s.ce;
        bus.StallEnable                  = s.stall;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [20:0] obs, exp;
        async_rst_n = 1'b0;
        model_reset();
        drive(S(1, 1, 'h10, 'h8, 1, 1, 'h18, 1, 0, -1, -1));
        repeat (2) @(negedge clk);
        #2;
        obs = observe();
        checks++;
        if (obs !== 21'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", obs);
        end
        $display("reset: outputs=%h", obs);
`ifdef SPECULATION_PREDICTOR_STATS_EN
        checks++;
        if ({pred_count, mis_count} !== 32'd0) begin
            errors++; $display("FAIL reset_stats got %h/%h want 0/0", pred_count, mis_count);
        end
`endif
        @(negedge clk);
        async_rst_n = 1'b1;
        drive(S(0, 0, 0, 0, 0, 0, 0, 1, 0, -1, -1));
        #1;
        exp = expect_out(); obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_release got %h want %h", obs, exp);
        end
        tick();
    endtask

    task automatic test_cold_relative();
        stim_t tbl[$];
        logic [20:0] obs, exp;
        tbl.push_back(S(1, 1, 'h10, 'h8, 0, 0, 0,     1, 0, 0, 'h8));  // cold miss
        tbl.push_back(S(0, 0, 0,    0,   1, 1, 'h18,  1, 0, -1, -1));  // allocate, counter 2
        tbl.push_back(S(1, 1, 'h18, 'h4, 0, 0, 0,     1, 0, 0, 'h4));  // alias miss
        tbl.push_back(S(0, 0, 0,    0,   1, 0, 'h19,  1, 0, -1, -1));
        tbl.push_back(S(1, 1, 'h10, 'h8, 0, 0, 0,     1, 0, 1, 'h8));  // now taken
        tbl.push_back(S(0, 0, 0,    0,   1, 1, 'h11,  1, 0, -1, -1));  // fell through -> counter 1
        tbl.push_back(S(1, 1, 'h10, 'h8, 0, 0, 0,     1, 0, 0, 'h8));
        tbl.push_back(S(0, 0, 0,    0,   1, 0, 'h11,  1, 0, -1, -1));
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            exp = expect_out(); obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL cold[%0d] outputs got %h want %h", i, obs, exp);
            end
            if (tbl[i].want_pred >= 0) begin
                checks++;
                if (bus.PredictingTrue !== 1'(tbl[i].want_pred) ||
                    bus.SpeculativeDestination !== 16'(tbl[i].want_dest)) begin
                    errors++;
                    $display("FAIL cold[%0d] pred/dest got %b/%h want %0d/%h", i,
                             bus.PredictingTrue, bus.SpeculativeDestination,
                             tbl[i].want_pred, tbl[i].want_dest);
                end
            end
            $display("cold[%0d] pc=%h begin=%b pred=%b dest=%h spec=%b", i, 16'(tbl[i].pc),
                     bus.BeginSpeculationPulse, bus.PredictingTrue,
                     bus.SpeculativeDestination, bus.Speculating);
            tick();
        end
`ifdef SPECULATION_PREDICTOR_STATS_EN
        checks++;
        if (pred_count !== 16'(m_pcount) || mis_count !== 16'(m_mcount)) begin
            errors++; $display("FAIL cold_stats got %0d/%0d want %0d/%0d",
                               pred_count, mis_count, m_pcount, m_mcount);
        end
`endif
    endtask

    task automatic test_absolute();
        stim_t tbl[$];
        logic [20:0] obs, exp;
        tbl.push_back(S(1, 0, 'h20, 0, 0, 0, 0,    1, 0, 0, -1));     // absolute miss
        tbl.push_back(S(0, 0, 0,    0, 1, 1, 'h40, 1, 0, -1, -1));
        tbl.push_back(S(1, 0, 'h20, 0, 0, 0, 0,    1, 0, 1, 'h40));
        tbl.push_back(S(0, 0, 0,    0, 1, 0, 'h40, 1, 0, -1, -1));    // counter 3
        tbl.push_back(S(1, 0, 'h20, 0, 0, 0, 0,    1, 0, 1, 'h40));
        tbl.push_back(S(0, 0, 0,    0, 1, 1, 'h50, 1, 0, -1, -1));    // retarget, stays 3
        tbl.push_back(S(1, 0, 'h20, 0, 0, 0, 0,    1, 0, 1, 'h50));
        tbl.push_back(S(0, 0, 0,    0, 1, 0, 'h50, 1, 0, -1, -1));
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            exp = expect_out(); obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL abs[%0d] outputs got %h want %h", i, obs, exp);
            end
            if (tbl[i].want_pred >= 0) begin
                checks++;
                if (bus.PredictingTrue !== 1'(tbl[i].want_pred) ||
                    (tbl[i].want_dest >= 0 && bus.SpeculativeDestination !== 16'(tbl[i].want_dest))) begin
                    errors++;
                    $display("FAIL abs[%0d] pred/dest got %b/%h want %0d/%h", i,
                             bus.PredictingTrue, bus.SpeculativeDestination,
                             tbl[i].want_pred, tbl[i].want_dest);
                end
            end
            $display("abs[%0d] pc=%h begin=%b pred=%b dest=%h spec=%b", i, 16'(tbl[i].pc),
                     bus.BeginSpeculationPulse, bus.PredictingTrue,
                     bus.SpeculativeDestination, bus.Speculating);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl[$];
        logic [20:0] obs, exp;
        tbl.push_back(S(1, 0, 'h13, 0, 0, 0, 0,    1, 0, 0, -1));
        tbl.push_back(S(1, 0, 'h13, 0, 0, 0, 0,    1, 0, -1, -1));    // held, no end
        tbl.push_back(S(1, 0, 'h13, 0, 1, 1, 'h77, 1, 0, -1, -1));    // held with end
        tbl.push_back(S(1, 0, 'h13, 0, 0, 0, 0,    1, 0, 1, 'h77));   // sees new entry
        tbl.push_back(S(0, 0, 0,    0, 1, 0, 'h77, 1, 0, -1, -1));
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            exp = expect_out(); obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL b2b[%0d] outputs got %h want %h", i, obs, exp);
            end
            if (tbl[i].want_pred >= 0) begin
                checks++;
                if (bus.BeginSpeculationPulse !== 1'b1 || bus.PredictingTrue !== 1'(tbl[i].want_pred) ||
                    (tbl[i].want_dest >= 0 && bus.SpeculativeDestination !== 16'(tbl[i].want_dest))) begin
                    errors++;
                    $display("FAIL b2b[%0d] begin/pred/dest got %b/%b/%h want 1/%0d/%h", i,
                             bus.BeginSpeculationPulse, bus.PredictingTrue,
                             bus.SpeculativeDestination, tbl[i].want_pred, tbl[i].want_dest);
                end
            end
            $display("b2b[%0d] begin=%b hold=%b pred=%b dest=%h spec=%b", i,
                     bus.BeginSpeculationPulse, bus.FetchHold, bus.PredictingTrue,
                     bus.SpeculativeDestination, bus.Speculating);
            tick();
        end
    endtask

    task automatic test_stall_clken();
        stim_t tbl[$];
        logic [20:0] obs, exp;
        tbl.push_back(S(1, 1, 'h25, 3, 0, 0, 0,    1, 1, -1, -1));    // stalled
        tbl.push_back(S(1, 1, 'h25, 3, 0, 0, 0,    0, 0, -1, -1));    // clock disabled
        tbl.push_back(S(0, 0, 0,    0, 1, 1, 'h9,  1, 0, -1, -1));    // end while idle
        tbl.push_back(S(1, 1, 'h25, 3, 0, 0, 0,    1, 0, 0, 3));
        tbl.push_back(S(0, 0, 0,    0, 1, 1, 'h28, 0, 0, -1, -1));    // end ignored, clk_en low
        tbl.push_back(S(0, 0, 0,    0, 1, 1, 'h28, 1, 1, -1, -1));    // end ignored, stalled
        tbl.push_back(S(0, 0, 0,    0, 1, 1, 'h28, 1, 0, -1, -1));
        tbl.push_back(S(0, 0, 0,    0, 0, 0, 0,    1, 0, -1, -1));
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            exp = expect_out(); obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL stall[%0d] outputs got %h want %h", i, obs, exp);
            end
            $display("stall[%0d] begin=%b hold=%b spec=%b", i,
                     bus.BeginSpeculationPulse, bus.FetchHold, bus.Speculating);
            tick();
        end
    endtask

    task automatic test_async_reset_mid_spec();
        logic [20:0] obs, exp;
        @(negedge clk);
        drive(S(1, 0, 'h20, 0, 0, 0, 0, 1, 0, -1, -1));
        #1;
        checks++;
        if (bus.PredictingTrue !== 1'b1) begin
            errors++; $display("FAIL arst_pre_pred got %b want 1", bus.PredictingTrue);
        end
        tick();
        @(negedge clk);
        #2;
        async_rst_n = 1'b0;
        #1;
        obs = observe();
        checks++;
        if (obs !== 21'd0) begin
            errors++; $display("FAIL arst_outputs got %h want 0", obs);
        end
        $display("arst: outputs during reset=%h", obs);
        model_reset();
        @(negedge clk);
        async_rst_n = 1'b1;
        drive(S(1, 0, 'h20, 0, 0, 0, 0, 1, 0, -1, -1));
        #1;
        exp = expect_out(); obs = observe();
        checks++;
        if (obs !== exp || bus.PredictingTrue !== 1'b0) begin
            errors++; $display("FAIL arst_table_cleared got %h want %h", obs, exp);
        end
        tick();
        @(negedge clk);
        drive(S(0, 0, 0, 0, 1, 0, 'h21, 1, 0, -1, -1));
        tick();
`ifdef SPECULATION_PREDICTOR_STATS_EN
        checks++;
        if (pred_count !== 16'(m_pcount) || mis_count !== 16'(m_mcount)) begin
            errors++; $display("FAIL arst_stats got %0d/%0d want %0d/%0d",
                               pred_count, mis_count, m_pcount, m_mcount);
        end
`endif
    endtask

    task automatic test_random();
        logic [20:0] obs, exp;
        stim_t s;
        for (int n = 0; n < 600; n++) begin
            s.pc = ($urandom_range(0, 19) == 0) ? 'hFFFF
                   : ($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
            s.fb    = ($urandom_range(0, 2) != 0);
            s.rel   = $urandom_range(0, 1);
            s.imm   = $urandom_range(0, 65535);
            s.en    = $urandom_range(0, 1);
            s.misp  = $urandom_range(0, 1);
            s.act   = ($urandom_range(0, 2) == 0) ? c_fall : $urandom_range(0, 63);
            s.ce    = ($urandom_range(0, 7) != 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.want_pred = -1; s.want_dest = -1;
            @(negedge clk);
            drive(s);
            #1;
            exp = expect_out(); obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rand[%0d] outputs got %h want %h", n, obs, exp);
            end
            if (bus.BeginSpeculationPulse)
                $display("rand[%0d] issue pc=%h pred=%b dest=%h", n, 16'(s.pc),
                         bus.PredictingTrue, bus.SpeculativeDestination);
            tick();
        end
`ifdef SPECULATION_PREDICTOR_STATS_EN
        checks++;
        if (pred_count !== 16'(m_pcount) || mis_count !== 16'(m_mcount)) begin
            errors++; $display("FAIL rand_stats got %0d/%0d want %0d/%0d",
                               pred_count, mis_count, m_pcount, m_mcount);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_relative();
        test_absolute();
        test_back_to_back();
        test_stall_clken();
        test_async_reset_mid_spec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
